// File: rtl/riscv_pkg.sv
// Shared core definitions: memory access size codes common to the decoder and the LSU.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic for the LSU: legality, byte enables, store replication
// and load extraction with sign/zero extension.
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign shifted_s = rdata >> {addr, 3'b000};
    assign byte_s    = shifted_s[7:0];
    assign half_s    = addr[1] ? rdata[31:16] : rdata[15:0];

    // Size decode: legality, enables and lane data for one access
    always_comb begin
        legal      = 1'b0;
        be         = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = 32'h0000_0000;
        case (size)
            LDST_B: begin
                legal      = 1'b1;
                be         = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{byte_s[7]}}, byte_s};
            end
            LDST_BU: begin
                legal      = ~we;
                be         = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {24'h00_0000, byte_s};
            end
            LDST_H: begin
                legal      = ~addr[0];
                be         = 4'b0011 << {addr[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{half_s[15]}}, half_s};
            end
            LDST_HU: begin
                legal      = ~addr[0] & ~we;
                be         = 4'b0011 << {addr[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {16'h0000, half_s};
            end
            LDST_W: begin
                legal      = (addr == 2'b00);
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
            end
            default: begin
                legal      = 1'b0;
                be         = 4'b0000;
                wdata_lane = wdata;
                rdata_ext  = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer: drives the req/gnt/rvalid data bus, stalls the core until
// the response arrives, and aborts with an error pulse when the bus never answers.
module riscv_lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd64
)(
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_stall_o,
    output logic        lsu_done_o,
    output logic        lsu_misalign_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
    localparam logic             TO_EN   = (TIMEOUT_CYCLES != 32'd0);

    logic [1:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             legal_s, legal_req_s, done_s, hit_s, bus_req_s, req_out_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s, rdata_ext_s;

    riscv_lsu_align u_align (
        .we         (lsu_we_i),
        .size       (lsu_size_i),
        .addr       (lsu_addr_i[1:0]),
        .wdata      (lsu_wdata_i),
        .rdata      (data_rdata_i),
        .legal      (legal_s),
        .be         (be_s),
        .wdata_lane (wdata_s),
        .rdata_ext  (rdata_ext_s)
    );

    // Completion wins over a timeout that expires on the response cycle
    always_comb begin
        legal_req_s = lsu_req_i & legal_s;
        done_s      = (state_r == ST_WAIT) & data_rvalid_i;
        hit_s       = TO_EN & (state_r != ST_IDLE) & (cnt_r == TO_LAST) & ~done_s;
        bus_req_s   = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                bus_req_s = legal_req_s;
                if (legal_req_s) begin
                    state_nxt_s = data_gnt_i ? ST_WAIT : ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                bus_req_s = ~hit_s;
                if (hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (data_gnt_i) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (done_s || hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if ((state_r == ST_IDLE) || (state_nxt_s == ST_IDLE)) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // FSM state and timeout counter
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Outputs are forced low while reset is asserted, even with a live request
    assign req_out_s      = arstn_i & bus_req_s;
    assign data_req_o     = req_out_s;
    assign data_we_o      = req_out_s & lsu_we_i;
    assign data_be_o      = req_out_s ? be_s : 4'b0000;
    assign data_addr_o    = req_out_s ? {lsu_addr_i[31:2], 2'b00} : 32'h0000_0000;
    assign data_wdata_o   = req_out_s ? wdata_s : 32'h0000_0000;
    assign lsu_done_o     = arstn_i & done_s;
    assign lsu_err_o      = arstn_i & hit_s;
    assign lsu_rdata_o    = (arstn_i & done_s) ? rdata_ext_s : 32'h0000_0000;
    assign lsu_misalign_o = arstn_i & lsu_req_i & ~legal_s;
    assign lsu_stall_o    = arstn_i & legal_req_s & ~done_s & ~hit_s;

endmodule
